seq_approx_divider: RTL and testbench

- Sequential, parametrised successor of the combinational triangular approximate array divider.
- Computes one quotient bit per clock from MSB to LSB, reusing a single DW-column row of subtractor cells.
- Per-transaction runtime choice of the size of the triangular approximate region; a level of 0 gives exact division.
- Valid/ready on input and output; sits as a divide unit in the approximate-arithmetic datapath.

---
 rtl/seq_approx_divider_pkg.sv | 40 ++++
 rtl/seq_approx_divider_div_row.sv | 49 ++++
 rtl/seq_approx_divider.sv | 148 ++++++++++++++
 tb/tb_seq_approx_divider.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_approx_divider_pkg.sv
// div_pkg: shared types and bit-level cell models for the sequential
// triangular approximate divider.
//   state_e     - controller states (IDLE, BUSY, DONE)
//   is_approx   - selects the approximate cell for row k, column j
//   exact_cell  - full ripple-borrow subtractor cell, returns {bout, diff}
//   approx_cell - approximate subtractor cell, returns {bout, diff}
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // The approximate region is the triangle of cells whose row+column index
  // lies below the requested level; level 0 therefore selects no cell.
  function automatic logic is_approx(input int k, input int j, input int lvl);
    return (k + j) < lvl;
  endfunction

  // Exact subtractor cell x - y - b.
  function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic b);
    logic diff;
    logic bout;
    diff = x ^ y ^ b;
    bout = (~x & y) | (~(x ^ y) & b);
    return {bout, diff};
  endfunction

  // Approximate subtractor cell: difference only survives when nothing is
  // subtracted, borrow only generated when y is set.
  function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic b);
    logic diff;
    logic bout;
    diff = x & ~y & ~b;
    bout = y & (~x | b);
    return {bout, diff};
  endfunction

endpackage

// File: rtl/seq_approx_divider_div_row.sv
// div_row: one combinational row of DW subtractor cells.
// Subtracts d from the low DW bits of the partial-remainder window and
// produces the quotient bit for this row plus the restored/reduced low bits.
//   x       - low DW bits of the window
//   top     - window MSB (forces a quotient 1 when set)
//   d       - divisor
//   k       - row index (quotient bit position)
//   lvl     - approximation level for this transaction
//   q_bit   - quotient bit for row k
//   new_low - difference when q_bit is 1, otherwise x unchanged
module div_row
  import div_pkg::*;
#(
  parameter int DW = 8,
  parameter int KW = (DW > 1) ? $clog2(DW) : 1,
  parameter int LW = $clog2(2 * DW)
) (
  input  logic [DW-1:0] x,
  input  logic          top,
  input  logic [DW-1:0] d,
  input  logic [KW-1:0] k,
  input  logic [LW-1:0] lvl,
  output logic          q_bit,
  output logic [DW-1:0] new_low
);

  logic [DW:0]   borrow;
  logic [DW-1:0] diff;

  assign borrow[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_col
      logic [1:0] cell_exact;
      logic [1:0] cell_approx;
      logic       use_approx;

      assign cell_exact  = exact_cell(x[gi], d[gi], borrow[gi]);
      assign cell_approx = approx_cell(x[gi], d[gi], borrow[gi]);
      assign use_approx  = is_approx(int'(k), gi, int'(lvl));
      assign {borrow[gi+1], diff[gi]} = use_approx ? cell_approx : cell_exact;
    end
  endgenerate

  // A set window MSB means the window already exceeds any DW-bit divisor.
  assign q_bit   = top | ~borrow[DW];
  assign new_low = q_bit ? diff : x;

endmodule

// File: rtl/seq_approx_divider.sv
// seq_approx_divider: sequential restoring divider, one quotient bit per
// clock from MSB to LSB, with a per-transaction triangular approximate
// region in the subtractor array.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_ready  - operand handshake (accepted only in IDLE)
//   n, d, approx_lvl    - 2*DW-bit numerator, DW-bit divisor, level (0 = exact)
//   out_valid, out_ready- result handshake (held in DONE until accepted)
//   q, r                - quotient and remainder (truncated array result)
//   div_by_zero, q_ovf  - d was zero / exact quotient exceeds DW bits
module seq_approx_divider
  import div_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = $clog2(2 * DW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] n,
  input  logic [DW-1:0]   d,
  input  logic [LW-1:0]   approx_lvl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   q,
  output logic [DW-1:0]   r,
  output logic            div_by_zero,
  output logic            q_ovf
);

  localparam int KW = (DW > 1) ? $clog2(DW) : 1;

  state_e        state_q, state_d;
  logic [DW:0]   w_q, w_d;        // partial-remainder window
  logic [DW-2:0] n_lo_q, n_lo_d;  // numerator bits still to be shifted in
  logic [DW-1:0] d_q, d_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic          row_q_bit;
  logic [DW-1:0] row_new_low;

  div_row #(
    .DW(DW),
    .KW(KW),
    .LW(LW)
  ) u_row (
    .x      (w_q[DW-1:0]),
    .top    (w_q[DW]),
    .d      (d_q),
    .k      (k_q),
    .lvl    (lvl_q),
    .q_bit  (row_q_bit),
    .new_low(row_new_low)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      n_lo_q  <= '0;
      d_q     <= '0;
      lvl_q   <= '0;
      k_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      n_lo_q  <= n_lo_d;
      d_q     <= d_d;
      lvl_q   <= lvl_d;
      k_q     <= k_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    n_lo_d    = n_lo_q;
    d_d       = d_q;
    lvl_d     = lvl_q;
    k_d       = k_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = BUSY;
          w_d     = n[2*DW-1:DW-1];
          n_lo_d  = n[DW-2:0];
          d_d     = d;
          lvl_d   = approx_lvl;
          k_d     = KW'(DW - 1);
          quo_d   = '0;
          rem_d   = '0;
          dbz_d   = (d == '0);
          ovf_d   = (n[2*DW-1:DW] >= d);
        end
      end

      BUSY: begin
        quo_d[k_q] = row_q_bit;
        if (k_q != '0) begin
          // Shift the next numerator bit into the window for row k-1.
          w_d = {row_new_low, n_lo_q[k_q - 1'b1]};
          k_d = k_q - 1'b1;
        end else begin
          rem_d   = row_new_low;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign q           = quo_q;
  assign r           = rem_q;
  assign div_by_zero = dbz_q;
  assign q_ovf       = ovf_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
module tb_seq_approx_divider;
  import div_pkg::*;

  localparam int DW = 8;
  localparam int LW = $clog2(2 * DW);
  localparam int TIMEOUT = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] n;
  logic [DW-1:0]   d;
  logic [LW-1:0]   approx_lvl;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   q;
  logic [DW-1:0]   r;
  logic            div_by_zero;
  logic            q_ovf;

  int checks = 0;
  int errors = 0;

  seq_approx_divider #(.DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .n          (n),
    .d          (d),
    .approx_lvl (approx_lvl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero),
    .q_ovf      (q_ovf)
  );

  always #5 clk = ~clk;

  // Reference: long division over the MSB-first windows, each row a
  // DW-column borrow chain whose columns pick exact or approximate cells.
  function automatic void model(input logic [2*DW-1:0] nn, input logic [DW-1:0] dd,
                                input int lvl, output logic [DW-1:0] qq,
                                output logic [DW-1:0] rr);
    logic [DW:0]   win;
    logic [DW-1:0] x;
    logic [DW-1:0] df;
    logic [1:0]    c;
    logic          b;
    logic          qb;
    win = nn[2*DW-1:DW-1];
    qq  = '0;
    rr  = '0;
    df  = '0;
    for (int k = DW - 1; k >= 0; k--) begin
      x = win[DW-1:0];
      b = 1'b0;
      for (int j = 0; j < DW; j++) begin
        if (is_approx(k, j, lvl)) c = approx_cell(x[j], dd[j], b);
        else                      c = exact_cell(x[j], dd[j], b);
        df[j] = c[0];
        b     = c[1];
      end
      qb    = win[DW] | ~b;
      qq[k] = qb;
      if (k > 0) win = {(qb ? df : x), nn[k-1]};
      else       rr  = qb ? df : x;
    end
  endfunction

  // One full transaction; lat = clock edges from accept to out_valid.
  task automatic run_op(input logic [2*DW-1:0] nn, input logic [DW-1:0] dd,
                        input logic [LW-1:0] ll,
                        output logic [DW-1:0] qq, output logic [DW-1:0] rr,
                        output logic zz, output logic oo, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!in_ready && wait_cnt < TIMEOUT) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_timeout got=%b want=1", in_ready);
    end
    n = nn; d = dd; approx_lvl = ll; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout got=%b want=1", out_valid);
    end
    qq = q; rr = r; zz = div_by_zero; oo = q_ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("op n=%h d=%h lvl=%0d -> q=%h r=%h dbz=%b ovf=%b lat=%0d",
             nn, dd, ll, qq, rr, zz, oo, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n = '0; d = '0; approx_lvl = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, q, r, div_by_zero, q_ovf} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h z=%b o=%b want rdy=1 vld=0 q=00 r=00 z=0 o=0",
               in_ready, out_valid, q, r, div_by_zero, q_ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exact();
    logic [DW-1:0] qq, rr; logic zz, oo; int lat;
    run_op(16'd100, 8'd7, 4'd0, qq, rr, zz, oo, lat);
    checks++;
    if ({qq, rr, zz, oo} !== {8'd14, 8'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exact_100_7 got q=%0d r=%0d z=%b o=%b want q=14 r=2 z=0 o=0", qq, rr, zz, oo);
    end
    checks++;
    if (lat !== DW) begin
      errors++;
      $display("FAIL latency got=%0d want=%0d", lat, DW);
    end
  endtask

  task automatic test_approx();
    logic [DW-1:0] qq, rr; logic zz, oo; int lat;
    run_op(16'd5, 8'd3, 4'd6, qq, rr, zz, oo, lat);
    checks++;
    if ({qq, rr} !== {8'h0F, 8'h00}) begin
      errors++;
      $display("FAIL approx_5_3_l6 got q=%h r=%h want q=0f r=00", qq, rr);
    end
    run_op(16'd5, 8'd3, 4'd0, qq, rr, zz, oo, lat);
    checks++;
    if ({qq, rr} !== {8'h01, 8'h02}) begin
      errors++;
      $display("FAIL approx_5_3_l0 got q=%h r=%h want q=01 r=02", qq, rr);
    end
  endtask

  task automatic test_div_zero();
    logic [DW-1:0] qq, rr; logic zz, oo; int lat;
    logic [LW-1:0] ll;
    ll = LW'($urandom_range(0, 2**LW - 1));
    run_op(16'h1234, 8'd0, ll, qq, rr, zz, oo, lat);
    checks++;
    if ({qq, rr, zz, oo} !== {8'hFF, 8'h34, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL div_zero lvl=%0d got q=%h r=%h z=%b o=%b want q=ff r=34 z=1 o=1",
               ll, qq, rr, zz, oo);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] qq, rr, mq, mr; logic zz, oo; int lat;
    run_op(16'h0800, 8'd8, 4'd0, qq, rr, zz, oo, lat);
    model(16'h0800, 8'd8, 0, mq, mr);
    checks++;
    if ({oo, zz, qq, rr} !== {1'b1, 1'b0, mq, mr}) begin
      errors++;
      $display("FAIL overflow got o=%b z=%b q=%h r=%h want o=1 z=0 q=%h r=%h", oo, zz, qq, rr, mq, mr);
    end
    // Just below the overflow boundary: 0x07FF / 8 fits in DW bits.
    run_op(16'h07FF, 8'd8, 4'd0, qq, rr, zz, oo, lat);
    checks++;
    if ({oo, qq, rr} !== {1'b0, 8'd255, 8'd7}) begin
      errors++;
      $display("FAIL no_overflow got o=%b q=%0d r=%0d want o=0 q=255 r=7", oo, qq, rr);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    n = 16'd200; d = 8'd9; approx_lvl = '0; in_valid = 1'b1;
    @(negedge clk);
    // Keep offering other operands; they must be ignored until IDLE.
    n = 16'hFFFF; d = 8'd1;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_ready got=%b want=0", in_ready);
      end
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, q, r} !== {1'b1, 1'b0, 8'd22, 8'd2}) begin
        errors++;
        $display("FAIL hold_done cyc=%0d got vld=%b rdy=%b q=%0d r=%0d want vld=1 rdy=0 q=22 r=2",
                 i, out_valid, in_ready, q, r);
      end
      @(negedge clk);
    end
    $display("op n=00c8 d=09 lvl=0 held 5 cycles -> q=%0d r=%0d", q, r);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] qq, rr; logic zz, oo; int lat;
    @(negedge clk);
    n = 16'd100; d = 8'd7; approx_lvl = '0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);  // rows 7,6,5 done; row 4 in progress
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, q, r, div_by_zero, q_ovf} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got vld=%b rdy=%b q=%h r=%h z=%b o=%b want vld=0 rdy=1 q=00 r=00 z=0 o=0",
               out_valid, in_ready, q, r, div_by_zero, q_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(16'd77, 8'd5, 4'd0, qq, rr, zz, oo, lat);
    checks++;
    if ({qq, rr, zz, oo} !== {8'd15, 8'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset got q=%0d r=%0d z=%b o=%b want q=15 r=2 z=0 o=0", qq, rr, zz, oo);
    end
  endtask

  task automatic test_random();
    logic [2*DW-1:0] nn; logic [DW-1:0] dd; logic [LW-1:0] ll;
    logic [DW-1:0] qq, rr, mq, mr; logic zz, oo, ez, eo; int lat;
    for (int t = 0; t < 1000; t++) begin
      nn = 16'($urandom);
      dd = 8'($urandom);
      if (t % 4 == 0) ll = '0;
      else            ll = LW'($urandom_range(0, 2**LW - 1));
      run_op(nn, dd, ll, qq, rr, zz, oo, lat);
      model(nn, dd, int'(ll), mq, mr);
      ez = (dd == 0);
      eo = ({8'h00, nn[15:8]} >= {8'h00, dd});
      checks++;
      if ({qq, rr, zz, oo} !== {mq, mr, ez, eo}) begin
        errors++;
        $display("FAIL random n=%h d=%h lvl=%0d got q=%h r=%h z=%b o=%b want q=%h r=%h z=%b o=%b",
                 nn, dd, ll, qq, rr, zz, oo, mq, mr, ez, eo);
      end
      if (ll == 0 && !eo) begin
        checks++;
        if ({qq, rr} !== {8'(nn / dd), 8'(nn % dd)}) begin
          errors++;
          $display("FAIL exact_arith n=%0d d=%0d got q=%0d r=%0d want q=%0d r=%0d",
                   nn, dd, qq, rr, nn / dd, nn % dd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
